// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss handler that writes back a dirty victim block,
// then refills the missing block word by word (optionally critical-word-first).
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   miss_detected          miss request from tag logic (taken in IDLE only)
//   miss_address           missing address
//   victim_dirty           victim needs writeback
//   victim_tag_addr        victim block address (offset bits ignored)
//   cache_rd_data          data-array read data for cache_rd_wrd_en word
//   memory_data(_valid)    memory read return, in issue order
//   fsm_busy               pipeline stall (not IDLE)
//   memory_address         request address
//   mem_rd_en / mem_wr_en  read / write request strobes
//   mem_wr_data            writeback data (= cache_rd_data)
//   cache_rd_wrd_en        one-hot victim word select during writeback
//   write_data_array       fill write strobe
//   wrd_en                 one-hot fill word select
//   data_array_wr_data     fill data (= memory_data)
//   write_tag_array        tag/valid write pulse once the block is complete
//   crit_word_done         pulse when the word holding miss_address is written
module cache_fill_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WORDS    = 8,
    parameter int BYTE_OFF = 1,
    parameter int CWF      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_tag_addr,
    input  logic [DATA_W-1:0] cache_rd_data,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic [ADDR_W-1:0] memory_address,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [WORDS-1:0]  cache_rd_wrd_en,
    output logic              write_data_array,
    output logic [WORDS-1:0]  wrd_en,
    output logic [DATA_W-1:0] data_array_wr_data,
    output logic              write_tag_array,
    output logic              crit_word_done
);

    localparam int IW  = $clog2(WORDS);
    localparam int CW  = IW + 1;
    localparam int OFF = IW + BYTE_OFF;

    localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF;
    localparam logic [CW-1:0]     LAST      = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL,
        DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] vbase_q;
    logic [IW-1:0]     crit_q;
    logic [CW-1:0]     icnt_q;
    logic [CW-1:0]     rcnt_q;
    logic              busy_q;
    logic              rd_q;
    logic              wr_q;
    logic              tag_q;

    logic [IW-1:0]     iidx;
    logic [IW-1:0]     ridx;
    logic              ret_ok;

    // Word order: plain ascending, or rotated to start at the critical word.
    assign iidx = (CWF != 0) ? crit_q + icnt_q[IW-1:0] : icnt_q[IW-1:0];
    assign ridx = (CWF != 0) ? crit_q + rcnt_q[IW-1:0] : rcnt_q[IW-1:0];

    // Returns count only while FILL; FILL is left on the last one,
    // so no extra bound on rcnt_q is needed here.
    assign ret_ok = (state_q == FILL) && memory_data_valid;

    always_comb begin
        memory_address = '0;
        if (wr_q) begin
            memory_address = vbase_q | (ADDR_W'(icnt_q[IW-1:0]) << BYTE_OFF);
        end else if (rd_q) begin
            memory_address = base_q | (ADDR_W'(iidx) << BYTE_OFF);
        end
    end

    assign cache_rd_wrd_en    = wr_q ? (WORDS'(1) << icnt_q[IW-1:0]) : '0;
    assign write_data_array   = ret_ok;
    assign wrd_en             = ret_ok ? (WORDS'(1) << ridx) : '0;
    assign crit_word_done     = ret_ok && (ridx == crit_q);
    assign mem_wr_data        = cache_rd_data;
    assign data_array_wr_data = memory_data;
    assign fsm_busy           = busy_q;
    assign mem_rd_en          = rd_q;
    assign mem_wr_en          = wr_q;
    assign write_tag_array    = tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            vbase_q <= '0;
            crit_q  <= '0;
            icnt_q  <= '0;
            rcnt_q  <= '0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            tag_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (miss_detected) begin
                        base_q  <= miss_address & BASE_MASK;
                        crit_q  <= miss_address[OFF-1:BYTE_OFF];
                        vbase_q <= victim_tag_addr & BASE_MASK;
                        icnt_q  <= '0;
                        rcnt_q  <= '0;
                        busy_q  <= 1'b1;
                        if (victim_dirty) begin
                            state_q <= WRITEBACK;
                            wr_q    <= 1'b1;
                        end else begin
                            state_q <= FILL;
                            rd_q    <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (icnt_q == LAST) begin
                        state_q <= FILL;
                        icnt_q  <= '0;
                        rcnt_q  <= '0;
                        wr_q    <= 1'b0;
                        rd_q    <= 1'b1;
                    end else begin
                        icnt_q <= icnt_q + 1'b1;
                    end
                end
                FILL: begin
                    if (rd_q) begin
                        icnt_q <= icnt_q + 1'b1;
                        rd_q   <= (icnt_q != LAST);
                    end
                    if (ret_ok) begin
                        if (rcnt_q == LAST) begin
                            state_q <= DONE;
                            icnt_q  <= '0;
                            rcnt_q  <= '0;
                            rd_q    <= 1'b0;
                            tag_q   <= 1'b1;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    tag_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed scenarios for cache_fill_ctrl
// (8-word CWF=0 / CWF=1 instances share stimulus; a 4-word 32-bit instance).
module tb_cache_fill_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic        miss, dirty, mval;
    logic [15:0] maddr, vaddr, crd, mdat;

    logic        busy0, rd0, wr0, wda0, tag0, crit0;
    logic [15:0] addr0, wdat0, dawd0;
    logic [7:0]  crwe0, wen0;
    logic        busy1, rd1, wr1, wda1, tag1, crit1;
    logic [15:0] addr1, wdat1, dawd1;
    logic [7:0]  crwe1, wen1;

    logic        miss4, dirty4, mval4;
    logic [31:0] maddr4, vaddr4, crd4, mdat4;
    logic        busy4, rd4, wr4, wda4, tag4, crit4;
    logic [31:0] addr4, wdat4, dawd4;
    logic [3:0]  crwe4, wen4;

    cache_fill_ctrl #(.CWF(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss), .miss_address(maddr),
        .victim_dirty(dirty), .victim_tag_addr(vaddr), .cache_rd_data(crd),
        .memory_data(mdat), .memory_data_valid(mval), .fsm_busy(busy0),
        .memory_address(addr0), .mem_rd_en(rd0), .mem_wr_en(wr0),
        .mem_wr_data(wdat0), .cache_rd_wrd_en(crwe0), .write_data_array(wda0),
        .wrd_en(wen0), .data_array_wr_data(dawd0), .write_tag_array(tag0),
        .crit_word_done(crit0));

    cache_fill_ctrl #(.CWF(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss), .miss_address(maddr),
        .victim_dirty(dirty), .victim_tag_addr(vaddr), .cache_rd_data(crd),
        .memory_data(mdat), .memory_data_valid(mval), .fsm_busy(busy1),
        .memory_address(addr1), .mem_rd_en(rd1), .mem_wr_en(wr1),
        .mem_wr_data(wdat1), .cache_rd_wrd_en(crwe1), .write_data_array(wda1),
        .wrd_en(wen1), .data_array_wr_data(dawd1), .write_tag_array(tag1),
        .crit_word_done(crit1));

    cache_fill_ctrl #(.ADDR_W(32), .DATA_W(32), .WORDS(4), .BYTE_OFF(2),
                      .CWF(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss4), .miss_address(maddr4),
        .victim_dirty(dirty4), .victim_tag_addr(vaddr4), .cache_rd_data(crd4),
        .memory_data(mdat4), .memory_data_valid(mval4), .fsm_busy(busy4),
        .memory_address(addr4), .mem_rd_en(rd4), .mem_wr_en(wr4),
        .mem_wr_data(wdat4), .cache_rd_wrd_en(crwe4), .write_data_array(wda4),
        .wrd_en(wen4), .data_array_wr_data(dawd4), .write_tag_array(tag4),
        .crit_word_done(crit4));

    task automatic test_reset();
        mval = 1'b1;
        mdat = 16'h5A5A;
        #1;
        total++; if ({busy0, rd0, wr0, wda0, tag0, crit0} !== 6'b0) begin bad++; $display("FAIL rst_ctl got=%b want=000000", {busy0, rd0, wr0, wda0, tag0, crit0}); end
        total++; if (addr0 !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h want=0000", addr0); end
        total++; if ({crwe0, wen0} !== 16'h0) begin bad++; $display("FAIL rst_en got=%h want=0000", {crwe0, wen0}); end
        total++; if (dawd0 !== 16'h5A5A) begin bad++; $display("FAIL rst_passthru got=%h want=5a5a", dawd0); end
        total++; if ({busy4, rd4, wr4, wda4, tag4} !== 5'b0) begin bad++; $display("FAIL rst_w4 got=%b want=00000", {busy4, rd4, wr4, wda4, tag4}); end
        mval = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Clean fill, memory latency 2.
    task automatic test_fill(input bit cwf);
        logic [15:0] ea [8];
        logic [7:0]  ew [8];
        int ck;
        int k;
        logic b, r, w, d, t, c;
        logic [15:0] a, dd;
        logic [7:0] e;
        if (cwf) begin
            ea = '{16'h1236, 16'h1238, 16'h123A, 16'h123C,
                   16'h123E, 16'h1230, 16'h1232, 16'h1234};
            ew = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
            ck = 0;
        end else begin
            ea = '{16'h1230, 16'h1232, 16'h1234, 16'h1236,
                   16'h1238, 16'h123A, 16'h123C, 16'h123E};
            ew = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
            ck = 3;
        end
        miss = 1'b1; maddr = 16'h1236; dirty = 1'b0; mval = 1'b0;
        @(posedge clk); #1;
        miss = 1'b0;
        for (int cyc = 0; cyc < 13; cyc++) begin
            mval = (cyc >= 2 && cyc < 10);
            mdat = 16'h0100 + 16'(cyc);
            k = cyc - 2;
            @(negedge clk);
            b = cwf ? busy1 : busy0; r = cwf ? rd1 : rd0; w = cwf ? wr1 : wr0;
            d = cwf ? wda1 : wda0; t = cwf ? tag1 : tag0; c = cwf ? crit1 : crit0;
            a = cwf ? addr1 : addr0; e = cwf ? wen1 : wen0; dd = cwf ? dawd1 : dawd0;
            total++; if (b !== (cyc <= 10)) begin bad++; $display("FAIL fill%0d_busy cyc=%0d got=%b", cwf, cyc, b); end
            total++; if (r !== (cyc < 8)) begin bad++; $display("FAIL fill%0d_rd cyc=%0d got=%b", cwf, cyc, r); end
            total++; if (w !== 1'b0) begin bad++; $display("FAIL fill%0d_wr cyc=%0d got=%b want=0", cwf, cyc, w); end
            if (cyc < 8) begin
                total++; if (a !== ea[cyc]) begin bad++; $display("FAIL fill%0d_addr cyc=%0d got=%h want=%h", cwf, cyc, a, ea[cyc]); end
            end
            total++; if (d !== mval) begin bad++; $display("FAIL fill%0d_wda cyc=%0d got=%b want=%b", cwf, cyc, d, mval); end
            if (mval) begin
                total++; if (e !== ew[k]) begin bad++; $display("FAIL fill%0d_wen cyc=%0d got=%h want=%h", cwf, cyc, e, ew[k]); end
                total++; if (c !== (k == ck)) begin bad++; $display("FAIL fill%0d_crit cyc=%0d got=%b", cwf, cyc, c); end
                total++; if (dd !== mdat) begin bad++; $display("FAIL fill%0d_data got=%h want=%h", cwf, dd, mdat); end
            end else begin
                total++; if ({e, c} !== 9'h0) begin bad++; $display("FAIL fill%0d_idle_wen cyc=%0d got=%h want=0", cwf, cyc, {e, c}); end
            end
            total++; if (t !== (cyc == 10)) begin bad++; $display("FAIL fill%0d_tag cyc=%0d got=%b", cwf, cyc, t); end
            @(posedge clk); #1;
        end
        mval = 1'b0;
    endtask

    // Dirty victim writeback then fill, latency 1.
    task automatic test_dirty();
        logic [15:0] ea;
        miss = 1'b1; maddr = 16'h1236; dirty = 1'b1; vaddr = 16'hA5F3; mval = 1'b0;
        @(posedge clk); #1;
        miss = 1'b0; dirty = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            crd = 16'hC0DE ^ 16'(cyc * 16'h0111);
            mval = (cyc >= 9 && cyc <= 16);
            mdat = 16'h7700 + 16'(cyc);
            @(negedge clk);
            total++; if (rd0 && wr0) begin bad++; $display("FAIL wb_overlap cyc=%0d got=11 want=not both", cyc); end
            total++; if (busy0 !== (cyc <= 17)) begin bad++; $display("FAIL wb_busy cyc=%0d got=%b", cyc, busy0); end
            total++; if (wr0 !== (cyc < 8)) begin bad++; $display("FAIL wb_wr cyc=%0d got=%b", cyc, wr0); end
            total++; if (rd0 !== (cyc >= 8 && cyc < 16)) begin bad++; $display("FAIL wb_rd cyc=%0d got=%b", cyc, rd0); end
            if (cyc < 8) begin
                ea = 16'hA5F0 + 16'(2 * cyc);
                total++; if (addr0 !== ea) begin bad++; $display("FAIL wb_addr cyc=%0d got=%h want=%h", cyc, addr0, ea); end
                total++; if (crwe0 !== (8'h01 << cyc)) begin bad++; $display("FAIL wb_crwe cyc=%0d got=%h", cyc, crwe0); end
                total++; if (wdat0 !== crd) begin bad++; $display("FAIL wb_wdata got=%h want=%h", wdat0, crd); end
            end else begin
                total++; if (crwe0 !== 8'h0) begin bad++; $display("FAIL wb_crwe_off cyc=%0d got=%h want=00", cyc, crwe0); end
            end
            if (cyc >= 8 && cyc < 16) begin
                ea = 16'h1230 + 16'(2 * (cyc - 8));
                total++; if (addr0 !== ea) begin bad++; $display("FAIL wb_rdaddr cyc=%0d got=%h want=%h", cyc, addr0, ea); end
            end
            total++; if (wda0 !== mval) begin bad++; $display("FAIL wb_wda cyc=%0d got=%b", cyc, wda0); end
            if (mval) begin
                total++; if (wen0 !== (8'h01 << (cyc - 9))) begin bad++; $display("FAIL wb_wen cyc=%0d got=%h", cyc, wen0); end
            end
            total++; if (tag0 !== (cyc == 17)) begin bad++; $display("FAIL wb_tag cyc=%0d got=%b", cyc, tag0); end
            @(posedge clk); #1;
        end
        mval = 1'b0;
    endtask

    // Irregular return gaps plus spurious valids in IDLE and after the block.
    task automatic test_gaps();
        logic [39:0] vmask;
        int nw;
        int nt;
        nw = 0; nt = 0;
        vmask = '0;
        vmask[3] = 1'b1; vmask[5] = 1'b1; vmask[9] = 1'b1; vmask[14] = 1'b1;
        vmask[17] = 1'b1; vmask[20] = 1'b1; vmask[24] = 1'b1; vmask[27] = 1'b1;
        vmask[28] = 1'b1; vmask[29] = 1'b1; vmask[31] = 1'b1;
        mval = 1'b1; mdat = 16'hDEAD;
        @(negedge clk);
        total++; if ({wda0, tag0, busy0} !== 3'b0) begin bad++; $display("FAIL gap_idle_valid got=%b want=000", {wda0, tag0, busy0}); end
        @(posedge clk); #1;
        miss = 1'b1; maddr = 16'h1236; dirty = 1'b0; mval = 1'b0;
        @(posedge clk); #1;
        miss = 1'b0;
        for (int cyc = 0; cyc < 36; cyc++) begin
            mval = vmask[cyc];
            @(negedge clk);
            if (wda0) begin
                total++; if (wen0 !== (8'h01 << nw)) begin bad++; $display("FAIL gap_wen n=%0d got=%h", nw, wen0); end
                nw++;
            end
            if (tag0) begin
                nt++;
                total++; if (cyc != 28) begin bad++; $display("FAIL gap_tag_cycle got=%0d want=28", cyc); end
            end
            @(posedge clk); #1;
        end
        mval = 1'b0;
        total++; if (nw != 8) begin bad++; $display("FAIL gap_writes got=%0d want=8", nw); end
        total++; if (nt != 1) begin bad++; $display("FAIL gap_tags got=%0d want=1", nt); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL gap_end_busy got=%b want=0", busy0); end
    endtask

    // Reset after the third return abandons the block.
    task automatic test_reset_mid();
        int nt;
        int nw;
        nt = 0; nw = 0;
        miss = 1'b1; maddr = 16'h1236; dirty = 1'b0; mval = 1'b0;
        @(posedge clk); #1;
        miss = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            mval = (cyc >= 1);
            @(posedge clk); #1;
        end
        mval = 1'b1;
        rst_n = 1'b0;
        #1;
        total++; if ({busy0, rd0, wr0, wda0, tag0, crit0} !== 6'b0) begin bad++; $display("FAIL rmid_ctl got=%b want=000000", {busy0, rd0, wr0, wda0, tag0, crit0}); end
        total++; if ({addr0, crwe0, wen0} !== 32'h0) begin bad++; $display("FAIL rmid_vec got=%h want=0", {addr0, crwe0, wen0}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            mval = cyc[0];
            @(negedge clk);
            if (tag0) nt++;
            if (wda0) nw++;
            @(posedge clk); #1;
        end
        mval = 1'b0;
        total++; if (nt != 0) begin bad++; $display("FAIL rmid_tag got=%0d want=0", nt); end
        total++; if (nw != 0) begin bad++; $display("FAIL rmid_wda got=%0d want=0", nw); end
    endtask

    // Miss held high: ignored while busy, re-accepted the cycle after DONE.
    task automatic test_back_to_back();
        logic [15:0] ea;
        miss = 1'b1; maddr = 16'h1236; dirty = 1'b0; mval = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            maddr = 16'h4440;
            mval = (cyc >= 1 && cyc <= 8);
            @(negedge clk);
            if (cyc < 8) begin
                ea = 16'h1230 + 16'(2 * cyc);
                total++; if (addr0 !== ea) begin bad++; $display("FAIL b2b_addr cyc=%0d got=%h want=%h", cyc, addr0, ea); end
            end
            if (mval) begin
                total++; if (wen0 !== (8'h01 << (cyc - 1))) begin bad++; $display("FAIL b2b_wen cyc=%0d got=%h", cyc, wen0); end
            end
            total++; if (tag0 !== (cyc == 9)) begin bad++; $display("FAIL b2b_tag cyc=%0d got=%b", cyc, tag0); end
            total++; if (busy0 !== (cyc != 10)) begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b", cyc, busy0); end
            if (cyc == 11) begin
                total++; if ({rd0, addr0} !== {1'b1, 16'h4440}) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/4440", rd0, addr0); end
            end
            @(posedge clk); #1;
        end
        miss = 1'b0; mval = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // 4 words x 32 bits, CWF=1, latency 1.
    task automatic test_w4();
        logic [31:0] ea [4];
        logic [3:0]  ew [4];
        ea = '{32'h100C, 32'h1000, 32'h1004, 32'h1008};
        ew = '{4'h8, 4'h1, 4'h2, 4'h4};
        miss4 = 1'b1; maddr4 = 32'h0000_100C; mval4 = 1'b0;
        @(posedge clk); #1;
        miss4 = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            mval4 = (cyc >= 1 && cyc <= 4);
            mdat4 = 32'hFACE_0000 + 32'(cyc);
            @(negedge clk);
            total++; if (busy4 !== (cyc <= 5)) begin bad++; $display("FAIL w4_busy cyc=%0d got=%b", cyc, busy4); end
            total++; if (rd4 !== (cyc < 4)) begin bad++; $display("FAIL w4_rd cyc=%0d got=%b", cyc, rd4); end
            if (cyc < 4) begin
                total++; if (addr4 !== ea[cyc]) begin bad++; $display("FAIL w4_addr cyc=%0d got=%h want=%h", cyc, addr4, ea[cyc]); end
            end
            if (mval4) begin
                total++; if (wen4 !== ew[cyc-1]) begin bad++; $display("FAIL w4_wen cyc=%0d got=%h want=%h", cyc, wen4, ew[cyc-1]); end
                total++; if (crit4 !== (cyc == 1)) begin bad++; $display("FAIL w4_crit cyc=%0d got=%b", cyc, crit4); end
                total++; if (dawd4 !== mdat4) begin bad++; $display("FAIL w4_data got=%h want=%h", dawd4, mdat4); end
            end
            total++; if (tag4 !== (cyc == 5)) begin bad++; $display("FAIL w4_tag cyc=%0d got=%b", cyc, tag4); end
            @(posedge clk); #1;
        end
        ea = '{32'h2004, 32'h2008, 32'h200C, 32'h2000};
        miss4 = 1'b1; maddr4 = 32'h0000_2004; mval4 = 1'b0;
        @(posedge clk); #1;
        miss4 = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            total++; if ({rd4, addr4} !== {1'b1, ea[cyc]}) begin bad++; $display("FAIL w4_wrap cyc=%0d got=%b/%h want=1/%h", cyc, rd4, addr4, ea[cyc]); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        miss = 1'b0; dirty = 1'b0; mval = 1'b0;
        maddr = '0; vaddr = '0; crd = '0; mdat = '0;
        miss4 = 1'b0; dirty4 = 1'b0; mval4 = 1'b0;
        maddr4 = '0; vaddr4 = '0; crd4 = '0; mdat4 = '0;
        test_reset();
        test_fill(1'b0);
        test_fill(1'b1);
        test_dirty();
        test_gaps();
        test_reset_mid();
        test_fill(1'b0);
        test_back_to_back();
        test_w4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
